// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: handshake FSM states and sideband message codes
// used by the MBINIT sub-state blocks.
package mbinit_pkg;

  localparam int MSG_W = 4;

  localparam logic [MSG_W-1:0] MSG_NONE              = '0;
  localparam logic [MSG_W-1:0] MSG_PARAM_REQ         = 4'h1;
  localparam logic [MSG_W-1:0] MSG_PARAM_RESP        = 4'h2;
  localparam logic [MSG_W-1:0] MSG_CAL_DONE_REQ      = 4'h3;
  localparam logic [MSG_W-1:0] MSG_CAL_DONE_RESP     = 4'h4;
  localparam logic [MSG_W-1:0] MSG_REPAIRCLK_REQ     = 4'h5;
  localparam logic [MSG_W-1:0] MSG_REPAIRCLK_RESP    = 4'h6;
  localparam logic [MSG_W-1:0] MSG_REPAIRVAL_REQ     = 4'h7;
  localparam logic [MSG_W-1:0] MSG_REPAIRVAL_RESP    = 4'h8;
  localparam logic [MSG_W-1:0] MSG_REVERSALMB_REQ    = 4'h9;
  localparam logic [MSG_W-1:0] MSG_REVERSALMB_RESP   = 4'hA;
  localparam logic [MSG_W-1:0] MSG_REPAIRMB_REQ      = 4'hB;
  localparam logic [MSG_W-1:0] MSG_REPAIRMB_RESP     = 4'hC;

  typedef enum logic [2:0] {
    SB_IDLE      = 3'd0,
    SB_SEND_REQ  = 3'd1,
    SB_WAIT_RESP = 3'd2,
    SB_DONE      = 3'd3,
    SB_ERROR     = 3'd4
  } sb_hs_state_e;

endpackage

// File: rtl/sb_timeout_counter.sv
// Cycle counter that flags the LIMIT-th enabled cycle since the last clear.
// Holds at its last value instead of wrapping.
module sb_timeout_counter #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/mbinit_sb_handshake.sv
// Sideband request/response engine for MBINIT: sends one code, waits for the
// expected reply with timeout and bounded resends, then reports done or error.
module mbinit_sb_handshake
  import mbinit_pkg::*;
#(
  parameter int MSG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [MSG_WIDTH-1:0] req_code,
  input  logic [MSG_WIDTH-1:0] exp_code,
  input  logic                 rx_valid,
  input  logic [MSG_WIDTH-1:0] rx_code,
  output logic                 tx_valid,
  output logic [MSG_WIDTH-1:0] tx_code,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           retry_cnt
);

  // Internal resend count is wide enough to reach MAX_RETRIES; retry_cnt only saturates.
  localparam int RW = $clog2(MAX_RETRIES + 2);

  sb_hs_state_e         state, state_next;
  logic [MSG_WIDTH-1:0] req_q, exp_q;
  logic [RW-1:0]        resend_q;
  logic                 accept, retry_inc;
  logic                 start_ok, match, expired;

  assign start_ok = start && (req_code != '0) && (exp_code != '0);
  // exp_q is never zero while waiting, so a zero rx code can never match.
  assign match    = rx_valid && (rx_code == exp_q);

  sb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == SB_SEND_REQ),
    .en      (state == SB_WAIT_RESP),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    retry_inc  = 1'b0;
    case (state)
      SB_IDLE, SB_ERROR: begin
        if (start_ok) begin
          state_next = SB_SEND_REQ;
          accept     = 1'b1;
        end
      end
      SB_SEND_REQ:  state_next = SB_WAIT_RESP;
      SB_WAIT_RESP: begin
        if (match) begin
          state_next = SB_DONE;
        end else if (expired) begin
          if (resend_q < RW'(MAX_RETRIES)) begin
            state_next = SB_SEND_REQ;
            retry_inc  = 1'b1;
          end else begin
            state_next = SB_ERROR;
          end
        end
      end
      SB_DONE:      state_next = SB_IDLE;
      default:      state_next = SB_IDLE;
    endcase
    if (abort) begin
      state_next = SB_IDLE;
      accept     = 1'b0;
      retry_inc  = 1'b0;
    end
  end

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SB_IDLE;
      req_q     <= '0;
      exp_q     <= '0;
      resend_q  <= '0;
      retry_cnt <= '0;
      tx_valid  <= 1'b0;
      tx_code   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        req_q     <= req_code;
        exp_q     <= exp_code;
        resend_q  <= '0;
        retry_cnt <= '0;
      end else if (retry_inc) begin
        resend_q <= resend_q + 1'b1;
        if (retry_cnt != 2'b11) begin
          retry_cnt <= retry_cnt + 1'b1;
        end
      end
      tx_valid <= (state_next == SB_SEND_REQ);
      tx_code  <= (state_next == SB_SEND_REQ) ? (accept ? req_code : req_q) : '0;
      busy     <= (state_next == SB_SEND_REQ) || (state_next == SB_WAIT_RESP);
      done     <= (state_next == SB_DONE);
      error    <= (state_next == SB_ERROR);
    end
  end

endmodule

// File: doc/mbinit_sb_handshake.md
# mbinit_sb_handshake

Request/response sideband handshake engine for the MBINIT sub-states of the LTSM. It issues one 4-bit sideband message code, then waits for a matching response code. It applies a cycle-count timeout with bounded retries and reports done or error to the sub-state controller. Its tx_code/tx_valid outputs feed the sideband path directly, including the fixed-latency signal delay stage used to model link latency. Its rx inputs consume the partner's delayed response.

## Interface
- MSG_WIDTH, 4: width of message codes; code 0 is reserved as "no message".
- TIMEOUT_CYCLES, 1000: cycles to wait in WAIT_RESP before a timeout (≥2).
- MAX_RETRIES, 2: extra resends after the first timeout (0 = no retry).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a handshake; sampled only in IDLE or ERROR.
- abort  in  1  forces return to IDLE from any state.
- req_code  in  MSG_WIDTH  code to send; latched on accepted start.
- exp_code  in  MSG_WIDTH  expected response code; latched on accepted start.
- rx_valid  in  1  incoming sideband message valid.
- rx_code  in  MSG_WIDTH  incoming message code.
- tx_valid  out  1  one-cycle pulse per transmitted request.
- tx_code  out  MSG_WIDTH  latched req_code while tx_valid=1, else 0.
- busy  out  1  high in SEND_REQ and WAIT_RESP.
- done  out  1  one-cycle pulse on matched response.
- error  out  1  level, high while in ERROR.
- retry_cnt  out  2  resends performed in the current handshake (saturating).

## Operation
- States: IDLE, SEND_REQ, WAIT_RESP, DONE, ERROR.
- IDLE: start=1 with req_code≠0 and exp_code≠0 latches both codes, clears retry_cnt, and moves to SEND_REQ. Start with either code 0 is ignored.
- SEND_REQ: tx_valid=1 and tx_code=latched code for exactly one cycle. The timeout counter clears. Next state is WAIT_RESP.
- WAIT_RESP: the counter increments every cycle.
  - rx_valid=1 with rx_code==exp_code → DONE.
  - Mismatched or zero rx codes are ignored.
  - Counter==TIMEOUT_CYCLES-1 with no match → SEND_REQ and retry_cnt+1 if retry_cnt<MAX_RETRIES; otherwise → ERROR.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: error held high. Accepted start behaves as in IDLE and clears error on the next edge. abort → IDLE.
- Simultaneous events:
  - abort beats everything.
  - A match in the timeout cycle counts as a match.
  - start while busy is ignored.
  - rx_valid in IDLE, DONE or ERROR is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES). The counter never wraps: it is cleared on entry to SEND_REQ.

## Timing
- Reset (async): state=IDLE. tx_valid, busy, done, error all 0. tx_code=0, retry_cnt=0, counter=0, latched codes=0.
- start at edge N → tx_valid high in cycle N+1 → WAIT_RESP from N+2.
- Match sampled at edge M → done high in cycle M+1 → IDLE at M+2.
- Timeout period: exactly TIMEOUT_CYCLES cycles in WAIT_RESP before the resend or the error.
- Worst-case failure latency from start: 1 + (MAX_RETRIES+1)·(TIMEOUT_CYCLES+1) cycles to error assertion.
- abort at edge A: IDLE from cycle A+1. An in-flight tx_valid is cancelled, and done/error are not asserted.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package mbinit_pkg:
  - sb_hs_state_e enum.
  - MSG_NONE='0.
  - MBINIT message code constants (PARAM req/resp, CAL done req/resp, REPAIRCLK, REPAIRVAL, etc.), shared with neighbouring MBINIT blocks.
- Sub-module sb_timeout_counter (params LIMIT; ports clk, rst_n, clr, en, expired): the natural split, reusable by other LTSM stages.
- FSM, code latches and output registers stay in the top module.

## Test plan
- Basic handshake: TIMEOUT_CYCLES=8. start with req=4'h5, exp=4'hA. Drive rx 4'hA 3 cycles after tx_valid → one tx_valid with tx_code=5, then done pulse; retry_cnt=0, error=0.
- Mismatch ignore: rx 4'h3 then 4'hA → only 4'hA completes; no extra tx_valid.
- Retry then success: no response for 8 cycles → second tx_valid 9 cycles after the first, retry_cnt=1. Respond 4'hA → done.
- Exhaustion: MAX_RETRIES=2, never respond → 3 tx_valid pulses, then error=1 held. A new start clears it and sends again.
- Boundary and abort:
  - Match on counter==7 → done, not a retry.
  - abort in WAIT_RESP → IDLE next cycle; a later rx 4'hA is ignored.
  - abort+start in the same cycle → stays IDLE.
- Reset mid-operation: rst_n low during WAIT_RESP → all outputs 0 immediately. After release, start with req=0 is ignored, and tx_valid stays 0.
